row_mac_engine: RTL and testbench
=================================

# row_mac_engine

Parametrised row dot-product engine: the successor to the single-mode row multiplier. On `start` it streams one image vector and one weight row from the pixel and weight SRAMs, multiplies `LANES` packed element pairs per cycle, and accumulates signed sums in a wide accumulator. It then presents a saturated or wrapped `OUT_W` result with a one-cycle write strobe to the result store. Compared with the previous block it adds configurable read latency, signed weights, saturation mode, abort, and out-of-range row detection.

## Interface
Parameters:
- `LANES`, 2, element pairs per memory word
- `PIX_W`, 8, unsigned pixel element width
- `WGT_W`, 16, signed (two's complement) weight element width
- `ACC_W`, 32, signed accumulator width; wraps modulo 2^ACC_W, and sizing is the integrator's responsibility
- `OUT_W`, 16, signed result width
- `VEC_LEN`, 392, words per row
- `NUM_ROWS`, 10, rows in weight memory
- `RD_LAT`, 1, SRAM read latency in cycles (1..3)
- `PIX_BASE`, 0, pixel base address
- `WGT_BASE`, 0, weight base address
- `PADDR_W`, 10, pixel address width
- `WADDR_W`, 12, weight address width

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock
- `n_rst` in 1: asynchronous active-low reset
- `start` in 1: begin a row; sampled only in IDLE
- `abort` in 1: cancel the current row
- `row_select` in 4: weight row index, captured at start
- `sat_mode` in 1: 1 = clamp result, 0 = truncate; captured at start
- `pixel_value` in LANES*PIX_W: element i at bits [i*PIX_W +: PIX_W]
- `weight_value` in LANES*WGT_W: element i at bits [i*WGT_W +: WGT_W]
- `pixel_address` out PADDR_W: pixel read address
- `weight_address` out WADDR_W: weight read address
- `rd_en` out 1: SRAM read strobe
- `busy` out 1: high in ISSUE, DRAIN and DONE
- `done_row` out 1: one-cycle completion pulse
- `w_result_ena` out 1: one-cycle write strobe, coincident with `done_row`
- `row_result` out OUT_W: row result
- `overflow` out 1: final accumulator does not fit OUT_W signed
- `err` out 1: one-cycle pulse on a rejected start

## Operation
States and transitions:
- IDLE → ISSUE on `start` with `row_select` < NUM_ROWS.
  - On the same edge: capture `row_select` and `sat_mode`, clear the accumulator, set index to 0.
- A `start` with `row_select` ≥ NUM_ROWS pulses `err` for one cycle and stays in IDLE.
- ISSUE (VEC_LEN cycles):
  - `rd_en` = 1.
  - `pixel_address` = PIX_BASE + idx.
  - `weight_address` = WGT_BASE + row*VEC_LEN + idx.
  - idx increments each cycle; after idx = VEC_LEN-1 → DRAIN.
- DRAIN (RD_LAT cycles):
  - `rd_en` = 0; addresses return to their bases.
  - Capture continues until the last word is accumulated, then → DONE.
- DONE (1 cycle):
  - `done_row` = `w_result_ena` = 1.
  - `row_result` and `overflow` update on entry to DONE.
  - Next state is IDLE.
- A RD_LAT-deep valid shift register tracks each issued read.
  - Data is accumulated in the cycle its valid bit emerges.
  - Per-word sum = Σ_i zero-extended pixel_i × sign-extended weight_i, computed exactly and then added to the accumulator.
- Result formatting, with acc = final accumulator:
  - `overflow` = acc > 2^(OUT_W-1)-1 or acc < -2^(OUT_W-1), independent of mode.
  - With `sat_mode` = 1: clamp to 0x7FFF / 0x8000 (for OUT_W = 16).
  - With `sat_mode` = 0: low OUT_W bits of acc.
- `row_result` and `overflow` hold until the next DONE or reset.

Boundary conditions:
- `start` while `busy` is ignored.
- `start` and `abort` together in IDLE: `abort` wins, no row starts.
- `abort` in ISSUE or DRAIN: IDLE on the next edge. No `done_row`, `row_result` unchanged, in-flight reads discarded.
- `abort` in DONE: ignored.

## Timing
- Reset values: all outputs 0. Addresses are PIX_BASE and WGT_BASE, state is IDLE, the accumulator is 0, and the valid pipeline is cleared.
- Start sampled at edge E0:
  - First `rd_en` cycle follows E0.
  - `done_row` is high in cycle VEC_LEN+RD_LAT+1 after E0.
  - `busy` falls one cycle later.
- Throughput: one row per VEC_LEN+RD_LAT+2 cycles, including one IDLE cycle.
- `n_rst` asserted mid-row: immediate return to reset values; no partial result is written.
- Memory data for the word addressed in cycle k must be valid in cycle k+RD_LAT.

## Test plan
1. LANES=2, VEC_LEN=4, RD_LAT=1, all pixel/weight elements 1, row_select=0 → addresses 0..3; `done_row`/`w_result_ena` pulse 6 cycles after start; `row_result`=8, `overflow`=0.
2. Pixels 255, weights 32767, VEC_LEN=4 → acc 66,844,680; `sat_mode`=1 gives 0x7FFF and `overflow`=1; `sat_mode`=0 gives 0xF808 and `overflow`=1.
3. Pixels 2, weights -3 (0xFFFD), VEC_LEN=4 → `row_result`=0xFFD0 (-48), `overflow`=0.
4. NUM_ROWS=10, VEC_LEN=4, row_select=3 → `weight_address` 12,13,14,15; row_select=10 → `err` pulse, `busy` stays 0, `row_result` unchanged.
5. `abort` at idx=2 → IDLE next cycle, no `done_row`, previous result held; `start` pulsed mid-row → ignored, single `done_row`.
6. RD_LAT=3, test 1 data → `done_row` 8 cycles after start, result 8; `n_rst` pulsed at idx=1 → all outputs 0, no `w_result_ena`.

Source files
------------

// File: rtl/row_mac_engine_if.sv
// Memory-side bus of row_mac_engine: paired pixel/weight SRAM read port.
// The engine drives addresses and the read strobe; the memories return packed element words.
interface row_mac_engine_if #(
    parameter int LANES   = 2,
    parameter int PIX_W   = 8,
    parameter int WGT_W   = 16,
    parameter int PADDR_W = 10,
    parameter int WADDR_W = 12
);
    logic [PADDR_W-1:0]     pixel_address;
    logic [WADDR_W-1:0]     weight_address;
    logic                   rd_en;
    logic [LANES*PIX_W-1:0] pixel_value;
    logic [LANES*WGT_W-1:0] weight_value;

    modport master (
        output pixel_address,
        output weight_address,
        output rd_en,
        input  pixel_value,
        input  weight_value
    );

    modport slave (
        input  pixel_address,
        input  weight_address,
        input  rd_en,
        output pixel_value,
        output weight_value
    );
endinterface

// File: rtl/row_mac_engine.sv
// Row dot-product engine: streams one pixel vector and one weight row, accumulates signed
// LANES-wide products, and emits a saturated or wrapped OUT_W result with a one-cycle strobe.
module row_mac_engine #(
    parameter int LANES    = 2,
    parameter int PIX_W    = 8,
    parameter int WGT_W    = 16,
    parameter int ACC_W    = 32,
    parameter int OUT_W    = 16,
    parameter int VEC_LEN  = 392,
    parameter int NUM_ROWS = 10,
    parameter int RD_LAT   = 1,
    parameter int PIX_BASE = 0,
    parameter int WGT_BASE = 0,
    parameter int PADDR_W  = 10,
    parameter int WADDR_W  = 12
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic             abort,
    input  logic [3:0]       row_select,
    input  logic             sat_mode,
    row_mac_engine_if.master mem,
    output logic             busy,
    output logic             done_row,
    output logic             w_result_ena,
    output logic [OUT_W-1:0] row_result,
    output logic             overflow,
    output logic             err
);
    localparam int IDX_W  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int PROD_W = PIX_W + WGT_W + 1;
    localparam int SUM_W  = PROD_W + $clog2(LANES) + 1;
    localparam int EXT_W  = (SUM_W > ACC_W) ? SUM_W : ACC_W;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic [1:0]              drain_cnt;
    logic [RD_LAT-1:0]       vld;
    logic                    sat_q;
    logic signed [ACC_W-1:0] acc;

    logic signed [EXT_W-1:0] word_sum;
    logic signed [ACC_W-1:0] acc_next;
    logic [ACC_W-OUT_W:0]    acc_hi;
    logic                    fits;
    logic [OUT_W-1:0]        fmt_result;
    logic                    row_ok;

    // Products are formed at EXT_W so the per-word sum is exact before it joins the accumulator.
    always_comb begin
        word_sum = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            word_sum = word_sum
                + $signed({{(EXT_W-PIX_W){1'b0}}, mem.pixel_value[i*PIX_W +: PIX_W]})
                * $signed({{(EXT_W-WGT_W){mem.weight_value[i*WGT_W + WGT_W - 1]}},
                           mem.weight_value[i*WGT_W +: WGT_W]});
        end
    end

    always_comb begin
        acc_next = acc;
        if (vld[RD_LAT-1]) begin
            acc_next = acc + word_sum[ACC_W-1:0];
        end
        acc_hi = acc_next[ACC_W-1:OUT_W-1];
        fits   = (acc_hi == '0) || (acc_hi == '1);
        if (fits || !sat_q) begin
            fmt_result = acc_next[OUT_W-1:0];
        end else if (acc_next[ACC_W-1]) begin
            fmt_result = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            fmt_result = {1'b0, {(OUT_W-1){1'b1}}};
        end
        row_ok = 32'(row_select) < 32'(NUM_ROWS);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state              <= IDLE;
            idx                <= '0;
            drain_cnt          <= '0;
            vld                <= '0;
            sat_q              <= 1'b0;
            acc                <= '0;
            mem.rd_en          <= 1'b0;
            mem.pixel_address  <= PADDR_W'(PIX_BASE);
            mem.weight_address <= WADDR_W'(WGT_BASE);
            busy               <= 1'b0;
            done_row           <= 1'b0;
            w_result_ena       <= 1'b0;
            row_result         <= '0;
            overflow           <= 1'b0;
            err                <= 1'b0;
        end else begin
            done_row     <= 1'b0;
            w_result_ena <= 1'b0;
            err          <= 1'b0;
            acc          <= acc_next;
            vld[0]       <= mem.rd_en;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                vld[i] <= vld[i-1];
            end

            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        if (row_ok) begin
                            state              <= ISSUE;
                            busy               <= 1'b1;
                            sat_q              <= sat_mode;
                            acc                <= '0;
                            idx                <= '0;
                            mem.rd_en          <= 1'b1;
                            mem.pixel_address  <= PADDR_W'(PIX_BASE);
                            mem.weight_address <= WADDR_W'(WGT_BASE)
                                                + WADDR_W'(row_select) * WADDR_W'(VEC_LEN);
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                ISSUE, DRAIN: begin
                    // Abort drops everything in flight; the held result is left untouched.
                    if (abort) begin
                        state              <= IDLE;
                        busy               <= 1'b0;
                        vld                <= '0;
                        mem.rd_en          <= 1'b0;
                        mem.pixel_address  <= PADDR_W'(PIX_BASE);
                        mem.weight_address <= WADDR_W'(WGT_BASE);
                    end else if (state == ISSUE) begin
                        if (idx == IDX_W'(VEC_LEN - 1)) begin
                            state              <= DRAIN;
                            drain_cnt          <= '0;
                            mem.rd_en          <= 1'b0;
                            mem.pixel_address  <= PADDR_W'(PIX_BASE);
                            mem.weight_address <= WADDR_W'(WGT_BASE);
                        end else begin
                            idx                <= idx + IDX_W'(1);
                            mem.pixel_address  <= mem.pixel_address + PADDR_W'(1);
                            mem.weight_address <= mem.weight_address + WADDR_W'(1);
                        end
                    end else if (drain_cnt == 2'(RD_LAT - 1)) begin
                        // The last word is folded in on this same edge via acc_next.
                        state        <= DONE;
                        done_row     <= 1'b1;
                        w_result_ena <= 1'b1;
                        row_result   <= fmt_result;
                        overflow     <= !fits;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_row_mac_engine.sv
// Self-checking bench for row_mac_engine: two instances (read latency 1 and 3) run in lockstep
// against shared SRAM contents, checked against constant vectors and a longint reference model.
module tb_row_mac_engine;
    localparam int LANES    = 2;
    localparam int PIX_W    = 8;
    localparam int WGT_W    = 16;
    localparam int ACC_W    = 32;
    localparam int OUT_W    = 16;
    localparam int VEC_LEN  = 4;
    localparam int NUM_ROWS = 10;
    localparam int PADDR_W  = 10;
    localparam int WADDR_W  = 12;
    localparam int PW       = LANES * PIX_W;
    localparam int WW       = LANES * WGT_W;
    localparam int WIN      = 14;
    localparam int LAT [2]  = '{1, 3};

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       sat_mode = 1'b0;
    logic [3:0] row_select = '0;

    always #5 clk = ~clk;

    logic [PW-1:0] pix_mem [1024];
    logic [WW-1:0] wgt_mem [4096];

    logic               busy [2];
    logic               done_row [2];
    logic               w_ena [2];
    logic               ovf [2];
    logic               err [2];
    logic               rd_en [2];
    logic [OUT_W-1:0]   res [2];
    logic [PADDR_W-1:0] paddr [2];
    logic [WADDR_W-1:0] waddr [2];

    row_mac_engine_if #(
        .LANES(LANES), .PIX_W(PIX_W), .WGT_W(WGT_W), .PADDR_W(PADDR_W), .WADDR_W(WADDR_W)
    ) mif [2] ();

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : 3;
        logic [PW-1:0] pst [L];
        logic [WW-1:0] wst [L];

        row_mac_engine #(
            .LANES(LANES), .PIX_W(PIX_W), .WGT_W(WGT_W), .ACC_W(ACC_W), .OUT_W(OUT_W),
            .VEC_LEN(VEC_LEN), .NUM_ROWS(NUM_ROWS), .RD_LAT(L), .PIX_BASE(0), .WGT_BASE(0),
            .PADDR_W(PADDR_W), .WADDR_W(WADDR_W)
        ) dut (
            .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
            .row_select(row_select), .sat_mode(sat_mode), .mem(mif[g]),
            .busy(busy[g]), .done_row(done_row[g]), .w_result_ena(w_ena[g]),
            .row_result(res[g]), .overflow(ovf[g]), .err(err[g])
        );

        // SRAM with L-cycle latency; junk is returned for cycles with no read.
        always @(posedge clk) begin
            pst[0] <= mif[g].rd_en ? pix_mem[mif[g].pixel_address] : PW'($urandom);
            wst[0] <= mif[g].rd_en ? wgt_mem[mif[g].weight_address] : WW'($urandom);
            for (int i = 1; i < L; i++) begin
                pst[i] <= pst[i-1];
                wst[i] <= wst[i-1];
            end
        end
        assign mif[g].pixel_value  = pst[L-1];
        assign mif[g].weight_value = wst[L-1];
        assign rd_en[g] = mif[g].rd_en;
        assign paddr[g] = mif[g].pixel_address;
        assign waddr[g] = mif[g].weight_address;
    end

    int               n_vec = 0;
    int               n_bad = 0;
    logic [OUT_W-1:0] prev_res [2] = '{16'h0, 16'h0};
    bit               prev_ovf [2] = '{1'b0, 1'b0};

    task automatic chk(input string name, input int g, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (RD_LAT=%0d): got %0d, expected %0d", name, LAT[g], act, exp);
        end
    endtask

    function automatic void ref_row(input int row, input bit sat,
                                    output logic [OUT_W-1:0] r, output bit o);
        longint acc = 0;
        int     a32;
        for (int k = 0; k < VEC_LEN; k++) begin
            logic [PW-1:0] pw = pix_mem[k];
            logic [WW-1:0] ww = wgt_mem[row*VEC_LEN + k];
            for (int i = 0; i < LANES; i++) begin
                logic [PIX_W-1:0]        p = pw[i*PIX_W +: PIX_W];
                logic signed [WGT_W-1:0] w = ww[i*WGT_W +: WGT_W];
                acc += longint'(p) * longint'(w);
            end
        end
        a32 = int'(acc);
        o = (a32 > 32767) || (a32 < -32768);
        if (o && sat) r = (a32 < 0) ? 16'h8000 : 16'h7FFF;
        else          r = 16'(a32);
    endfunction

    task automatic fill_uniform(input logic [PIX_W-1:0] pv, input logic [WGT_W-1:0] wv);
        for (int k = 0; k < VEC_LEN; k++) pix_mem[k] = {LANES{pv}};
        for (int k = 0; k < NUM_ROWS*VEC_LEN; k++) wgt_mem[k] = {LANES{wv}};
    endtask

    task automatic fill_random();
        for (int k = 0; k < VEC_LEN; k++) pix_mem[k] = PW'($urandom);
        for (int k = 0; k < NUM_ROWS*VEC_LEN; k++) begin
            logic [WW-1:0] w = '0;
            for (int l = 0; l < LANES; l++) begin
                int s = int'($urandom_range(0, 127)) - 64;
                w[l*WGT_W +: WGT_W] = ($urandom_range(0, 1) == 1) ? WGT_W'($urandom) : WGT_W'(s);
            end
            wgt_mem[k] = w;
        end
    endtask

    // One row from IDLE; abort/restart/reset are injected at the given cycle after the start edge.
    task automatic run_row(input int row, input bit sat, input int abort_at, input int restart_at,
                           input int rst_at, input logic [OUT_W-1:0] new_res, input bit new_ovf);
        int  dcyc [2], nd [2], wcyc [2], nwe [2], bfall [2], nrd [2], abad [2], frd [2];
        bit  seen_busy [2];
        for (int g = 0; g < 2; g++) begin
            dcyc[g] = 0; nd[g] = 0; wcyc[g] = 0; nwe[g] = 0; bfall[g] = 0;
            nrd[g] = 0; abad[g] = 0; frd[g] = 0; seen_busy[g] = 1'b0;
        end
        row_select = 4'(row);
        sat_mode   = sat;
        start      = 1'b1;
        for (int c = 1; c <= WIN; c++) begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                int d = VEC_LEN + LAT[g] + 1;
                if (done_row[g]) begin nd[g]++; if (dcyc[g] == 0) dcyc[g] = c; end
                if (w_ena[g]) begin nwe[g]++; if (wcyc[g] == 0) wcyc[g] = c; end
                if (busy[g]) seen_busy[g] = 1'b1;
                else if (seen_busy[g] && bfall[g] == 0) bfall[g] = c;
                if (rd_en[g]) begin
                    if (frd[g] == 0) frd[g] = c;
                    if (paddr[g] != PADDR_W'(nrd[g]) || waddr[g] != WADDR_W'(row*VEC_LEN + nrd[g]))
                        abad[g]++;
                    nrd[g]++;
                end
                if (c == 1) chk("busy_after_start", g, busy[g], 1);
                if (rst_at != 0 && c == rst_at + 1)
                    chk("reset_clears_outputs", g, {busy[g], done_row[g], w_ena[g], ovf[g], err[g],
                                                   rd_en[g], res[g], paddr[g], waddr[g]}, 0);
                if (abort_at != 0 && c == abort_at + 1 && abort_at < d &&
                    (rst_at == 0 || rst_at > abort_at))
                    chk("abort_to_idle", g, busy[g], 0);
            end
            start      = (c == restart_at);
            row_select = (c == restart_at) ? 4'((row + 1) % NUM_ROWS) : 4'(row);
            abort      = (c == abort_at);
            n_rst      = !(rst_at != 0 && c == rst_at);
        end
        start = 1'b0;
        abort = 1'b0;
        n_rst = 1'b1;
        for (int g = 0; g < 2; g++) begin
            int  d = VEC_LEN + LAT[g] + 1;
            bit  killed = (rst_at != 0 && rst_at < d);
            bit  comp = (abort_at == 0 || abort_at >= d) && !killed;
            if (comp) begin
                chk("done_cycle", g, dcyc[g], d);
                chk("done_count", g, nd[g], 1);
                chk("wena_cycle", g, wcyc[g], d);
                chk("wena_count", g, nwe[g], 1);
                chk("busy_fall_cycle", g, bfall[g], d + 1);
                chk("first_rd_cycle", g, frd[g], 1);
                chk("rd_count", g, nrd[g], VEC_LEN);
                chk("addr_seq_errors", g, abad[g], 0);
                prev_res[g] = new_res;
                prev_ovf[g] = new_ovf;
            end else begin
                chk("done_count_none", g, nd[g], 0);
                chk("wena_count_none", g, nwe[g], 0);
                if (killed) begin
                    prev_res[g] = '0;
                    prev_ovf[g] = 1'b0;
                end
            end
            chk("row_result", g, res[g], prev_res[g]);
            chk("overflow", g, ovf[g], prev_ovf[g]);
        end
    endtask

    typedef struct {
        logic [PIX_W-1:0] pv;
        logic [WGT_W-1:0] wv;
        int               row;
        bit               sat;
        logic [OUT_W-1:0] res;
        bit               ovf;
    } vec_t;

    vec_t             tab [8];
    int               row_r;
    int               ab_r;
    bit               sat_r;
    logic [OUT_W-1:0] er;
    bit               eo;

    initial begin
        tab[0] = '{8'd1,   16'd1,    0, 1'b1, 16'd8,    1'b0};
        tab[1] = '{8'd255, 16'h7FFF, 0, 1'b1, 16'h7FFF, 1'b1};
        tab[2] = '{8'd255, 16'h7FFF, 1, 1'b0, 16'hF808, 1'b1};
        tab[3] = '{8'd2,   16'hFFFD, 2, 1'b0, 16'hFFD0, 1'b0};
        tab[4] = '{8'd1,   16'd1,    3, 1'b0, 16'd8,    1'b0};
        tab[5] = '{8'd255, 16'h8000, 9, 1'b1, 16'h8000, 1'b1};
        tab[6] = '{8'd255, 16'h8000, 9, 1'b0, 16'h0000, 1'b1};
        tab[7] = '{8'd2,   16'hFFFD, 5, 1'b1, 16'hFFD0, 1'b0};

        for (int k = 0; k < 1024; k++) pix_mem[k] = '0;
        for (int k = 0; k < 4096; k++) wgt_mem[k] = '0;

        repeat (2) @(negedge clk);
        for (int g = 0; g < 2; g++)
            chk("reset_state", g, {busy[g], done_row[g], w_ena[g], ovf[g], err[g],
                                  rd_en[g], res[g], paddr[g], waddr[g]}, 0);
        n_rst = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 8; t++) begin
            fill_uniform(tab[t].pv, tab[t].wv);
            run_row(tab[t].row, tab[t].sat, 0, 0, 0, tab[t].res, tab[t].ovf);
        end

        // Out-of-range rows: error pulse only, engine stays idle and keeps its result.
        for (int r = 10; r <= 15; r += 5) begin
            row_select = 4'(r);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int g = 0; g < 2; g++) begin
                chk("err_pulse", g, err[g], 1);
                chk("err_busy", g, busy[g], 0);
            end
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                chk("err_one_cycle", g, err[g], 0);
                chk("err_no_read", g, rd_en[g], 0);
                chk("err_result_held", g, res[g], prev_res[g]);
            end
        end

        // start together with abort in IDLE: nothing begins.
        row_select = 4'd0;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        for (int g = 0; g < 2; g++) begin
            chk("start_abort_busy", g, busy[g], 0);
            chk("start_abort_rd", g, rd_en[g], 0);
        end
        @(negedge clk);

        fill_random();
        ref_row(1, 1'b0, er, eo);
        run_row(1, 1'b0, 0, 0, 0, er, eo);
        ref_row(2, 1'b1, er, eo);
        run_row(2, 1'b1, 3, 0, 0, er, eo);
        ref_row(4, 1'b0, er, eo);
        run_row(4, 1'b0, 6, 0, 0, er, eo);
        ref_row(7, 1'b1, er, eo);
        run_row(7, 1'b1, 0, 2, 0, er, eo);
        ref_row(8, 1'b0, er, eo);
        run_row(8, 1'b0, 0, 0, 2, er, eo);

        for (int r = 0; r < 24; r++) begin
            fill_random();
            row_r = int'($urandom_range(0, NUM_ROWS - 1));
            sat_r = 1'($urandom_range(0, 1));
            ab_r  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 9)) : 0;
            ref_row(row_r, sat_r, er, eo);
            run_row(row_r, sat_r, ab_r, 0, 0, er, eo);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
